// File: rtl/laplacian_frame_ctrl_if.sv
// Bus bundle between the frame sequencer, the source and destination frame
// buffers, and the laplacian filter core. The sequencer is the master side.
interface laplacian_frame_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              lap_valid_in;
    logic [7:0]        lap_pixel_in;
    logic              lap_valid_out;
    logic [7:0]        lap_pixel_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output lap_valid_in,
        output lap_pixel_in,
        input  lap_valid_out,
        input  lap_pixel_out,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  lap_valid_in,
        input  lap_pixel_in,
        output lap_valid_out,
        output lap_pixel_out,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/laplacian_frame_ctrl.sv
// Frame-level sequencer for the laplacian core: streams one frame out of the
// source buffer into the core in raster order and collects the filtered
// pixels into the destination buffer at sequential addresses.
module laplacian_frame_ctrl #(
    parameter int IMG_W         = 64,
    parameter int IMG_H         = 64,
    parameter int OUT_PIXELS    = (IMG_W - 2) * (IMG_H - 2),
    parameter int ADDR_W        = 12,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    laplacian_frame_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Counters carry one extra bit so the full-frame count never wraps to 0.
    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  FRAME_CNT   = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0]  FRAME_LAST  = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W-1:0]  OUT_CNT_MAX = CNT_W'(OUT_PIXELS);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(DRAIN_TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              rd_issue;
    logic              start_accept;
    logic              active;
    logic              capture;
    logic              overflow;
    logic              timeout;
    logic              beat_valid;
    logic [7:0]        pix_hold;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              error_q;

    // Next-state decode plus the state-derived control strobes.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        rd_issue     = 1'b0;
        start_accept = 1'b0;
        active       = 1'b0;
        case (state)
            ST_IDLE: begin
                start_accept = start;
                if (start) begin
                    state_nxt = ST_FEED;
                end
            end
            ST_FEED: begin
                busy     = 1'b1;
                active   = 1'b1;
                rd_issue = !pause && (in_cnt < FRAME_CNT);
                if (rd_issue && (in_cnt == FRAME_LAST)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy   = 1'b1;
                active = 1'b1;
                if ((out_cnt == OUT_CNT_MAX) || (idle_cnt == IDLE_LIMIT)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign capture  = active && bus.lap_valid_out && (out_cnt < OUT_CNT_MAX);
    assign overflow = active && bus.lap_valid_out && !(out_cnt < OUT_CNT_MAX);
    assign timeout  = (state == ST_DRAIN) && (out_cnt != OUT_CNT_MAX) && (idle_cnt == IDLE_LIMIT);

    // State register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read side: issue counter and the one-cycle source latency stage.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            in_cnt     <= '0;
            beat_valid <= 1'b0;
            pix_hold   <= '0;
        end else begin
            if (start_accept) begin
                in_cnt <= '0;
            end else if (rd_issue) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end
            beat_valid <= rd_issue;
            if (beat_valid) begin
                pix_hold <= bus.rd_data;
            end
        end
    end

    // Write side: capture each accepted core output into the next slot.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            out_cnt   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_accept) begin
                out_cnt <= '0;
            end else if (capture) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= out_cnt[ADDR_W-1:0];
                wr_data_q <= bus.lap_pixel_out;
                out_cnt   <= out_cnt + CNT_W'(1);
            end
        end
    end

    // Drain watchdog and the sticky error flag.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state != ST_DRAIN) begin
                idle_cnt <= '0;
            end else if (bus.lap_valid_out) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (start_accept) begin
                error_q <= 1'b0;
            end else if (overflow || timeout) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error            = error_q;
    assign bus.rd_en        = rd_issue;
    assign bus.rd_addr      = rd_issue ? in_cnt[ADDR_W-1:0] : '0;
    assign bus.lap_valid_in = beat_valid;
    assign bus.lap_pixel_in = beat_valid ? bus.rd_data : pix_hold;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;

endmodule

// File: doc/laplacian_frame_ctrl.md
Name: laplacian_frame_ctrl

Overview:
- Frame-level sequencer for the `laplacian` filter core.
- On `start`, fetches one IMG_W x IMG_H frame, pixel by pixel in raster order, from a 1-cycle-latency source memory and drives the core's `valid_in`/`pixel_in`.
- Collects the core's `valid_out`/`pixel_out` into a destination memory at sequential addresses.
- Reports `busy`/`done`/`error` to the host. Sits between the frame buffers and the `laplacian` instance.

Parameters:
- IMG_W, 64, frame width in pixels (>=3)
- IMG_H, 64, frame height in pixels (>=3)
- OUT_PIXELS, 3844, number of `valid_out` beats expected per frame (default (IMG_W-2)*(IMG_H-2))
- ADDR_W, 12, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- DRAIN_TIMEOUT, 256, max idle cycles in DRAIN without a `valid_out` before error

Ports:
- CLK  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a frame when in IDLE
- pause  in  1  level; while high no new source reads are issued
- busy  out  1  high in FEED and DRAIN
- done  out  1  one-cycle pulse on frame completion (normal or error)
- error  out  1  sticky until next accepted start; timeout or output overflow
- rd_en  out  1  source memory read strobe
- rd_addr  out  ADDR_W  source read address
- rd_data  in  8  source data, valid the cycle after rd_en
- lap_valid_in  out  1  to core `valid_in`
- lap_pixel_in  out  8  to core `pixel_in`
- lap_valid_out  in  1  from core `valid_out`
- lap_pixel_out  in  8  from core `pixel_out`
- wr_en  out  1  destination write strobe
- wr_addr  out  ADDR_W  destination write address
- wr_data  out  8  destination write data

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: busy, done, error, rd_en, rd_addr, lap_valid_in, lap_pixel_in, wr_en, wr_addr, wr_data. Internal in_cnt and out_cnt are 0. The operation in flight is abandoned; there is no resume.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 -> FEED. Clears in_cnt, out_cnt and error. start is ignored in every other state.
- FEED, read issue: while pause=0 and in_cnt < IMG_W*IMG_H, assert rd_en with rd_addr=in_cnt, then increment in_cnt. While pause=1, rd_en=0 and in_cnt holds.
- FEED, core drive: registered pipeline. Cycle after rd_en=1: lap_valid_in=1, lap_pixel_in=rd_data. A read already in flight when pause rises still completes. lap_valid_in=0 on any cycle with no read returning. lap_pixel_in holds its last value when invalid.
- FEED -> DRAIN: in the cycle after the last read is issued, i.e. in_cnt reaches IMG_W*IMG_H. The final lap_valid_in beat occurs in that same cycle.
- Output capture (FEED and DRAIN only): on lap_valid_out=1 with out_cnt < OUT_PIXELS, next cycle wr_en=1, wr_addr=out_cnt, wr_data=lap_pixel_out, then out_cnt increments.
  - lap_valid_out=1 with out_cnt == OUT_PIXELS: no write, error=1.
  - lap_valid_out in IDLE or DONE is ignored.
- DRAIN:
  - Idle counter resets on each lap_valid_out and increments otherwise.
  - out_cnt == OUT_PIXELS (after its final write) -> DONE.
  - Idle counter reaches DRAIN_TIMEOUT -> error=1, then DONE.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE. error stays visible until the next accepted start.
- busy=1 exactly while state is FEED or DRAIN.
- Latency from start to first rd_en: 1 cycle (start sampled in IDLE; rd_en asserted in the first FEED cycle).
- Counters: in_cnt/out_cnt are ADDR_W+1 bits so full-frame equality never wraps. The drain idle counter is sized to hold DRAIN_TIMEOUT.
- Simultaneous events:
  - pause rising in the same cycle the last read would issue: the read is not issued and FEED continues.
  - lap_valid_out on the cycle of the DRAIN->DONE decision is handled by the overflow rule.

Test Plan:
- Nominal frame: IMG_W=IMG_H=4, OUT_PIXELS=4, source = 0..15, core model echoes each input as valid_out after 6 cycles, one pulse per output slot.
  - 16 consecutive rd_en, addr 0..15.
  - lap_valid_in high 16 consecutive cycles, starting 1 cycle after first rd_en.
  - 4 writes at wr_addr 0..3.
  - done pulses once; error=0.
- Pause mid-frame: pause=1 for 5 cycles after 7 reads.
  - rd_en=0 for those 5 cycles; lap_valid_in shows a 5-cycle gap after the 7th beat.
  - rd_addr resumes at 7; total reads = 16.
- Drain timeout: DRAIN_TIMEOUT=8, core model emits only 2 valid_out.
  - 8 idle DRAIN cycles -> error=1, done pulse, busy=0.
  - Next start clears error.
- Overflow: core model emits 5 valid_out with OUT_PIXELS=4.
  - Only 4 writes occur; error=1 at the 5th beat; done still pulses.
- Reset mid-FEED: assert rst asynchronously after 9 reads (not clock-aligned).
  - All outputs 0 immediately; state IDLE.
  - A subsequent start runs a full clean frame from rd_addr=0.
- start ignored: pulse start during FEED and during DRAIN.
  - No counter reset; frame completes normally with a single done pulse.
